// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, signs fixed at the end.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] opd_q;
    logic [WIDTH-1:0] araw_q;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q;
    logic             neg_q;
    logic             neg_r_q;
    logic             div0_q;

    logic             is_muldiv;
    logic             sgn_op;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rsh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    assign is_muldiv = (op == OP_MULT) || (op == OP_MULTU) ||
                       (op == OP_DIV)  || (op == OP_DIVU);
    assign sgn_op    = ~op[0];
    assign a_abs     = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign b_abs     = (sgn_op && b[WIDTH-1]) ? -b : b;

    // One iteration: add-then-shift-right for multiply, shift-then-subtract for divide
    always_comb begin
        sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, opd_q} : '0);
        rsh   = {acc_q, q_q[WIDTH-1]};
        diff  = rsh[WIDTH-1:0] - opd_q;
        ge    = rsh[WIDTH] || (rsh[WIDTH-1:0] >= opd_q);
        acc_d = sum[WIDTH:1];
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        if (is_div_q) begin
            acc_d = ge ? diff : rsh[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], ge};
        end
    end

    always_comb begin
        prod   = {acc_q, q_q};
        prod_s = neg_q ? -prod : prod;
        quo    = neg_q ? -q_q : q_q;
        rem    = neg_r_q ? -acc_q : acc_q;
        hi_d   = prod_s[2*WIDTH-1:WIDTH];
        lo_d   = prod_s[WIDTH-1:0];
        if (is_div_q) begin
            hi_d = rem;
            lo_d = quo;
            if (div0_q) begin
                hi_d = araw_q;
                lo_d = '1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            opd_q    <= '0;
            araw_q   <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start && is_muldiv) begin
                        state_q  <= S_CALC;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        is_div_q <= op[1];
                        neg_q    <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_q  <= sgn_op & op[1] & a[WIDTH-1];
                        div0_q   <= op[1] & (b == '0);
                        araw_q   <= a;
                        q_q      <= op[1] ? a_abs : b_abs;
                        opd_q    <= op[1] ? b_abs : a_abs;
                    end else if (start && op == OP_MTHI) begin
                        hi_q <= a;
                    end else if (start && op == OP_MTLO) begin
                        lo_q <= a;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases pinned to literals plus random traffic
// checked every cycle against an arithmetic reference with a latency counter.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_calc(input logic [2:0] o,
                                     input logic [W-1:0] x,
                                     input logic [W-1:0] y,
                                     output logic [W-1:0] rh,
                                     output logic [W-1:0] rl);
        longint sx;
        longint sy;
        logic [63:0] p;
        int xi;
        int yi;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        xi = $signed(x);
        yi = $signed(y);
        p  = '0;
        rh = '0;
        rl = '0;
        case (o)
            3'd0: begin
                p  = 64'(sx * sy);
                rh = p[63:32];
                rl = p[31:0];
            end
            3'd1: begin
                p  = {32'd0, x} * {32'd0, y};
                rh = p[63:32];
                rl = p[31:0];
            end
            3'd2: begin
                if (y == 0) begin
                    rh = x;
                    rl = '1;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    rh = '0;
                    rl = 32'h8000_0000;
                end else begin
                    rl = xi / yi;
                    rh = xi % yi;
                end
            end
            3'd3: begin
                if (y == 0) begin
                    rh = x;
                    rl = '1;
                end else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
            default: ;
        endcase
    endfunction

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] p_hi = '0;
    logic [W-1:0] p_lo = '0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                end
            end else if (start) begin
                case (op)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        ref_calc(op, a, b, p_hi, p_lo);
                        m_busy = 1'b1;
                        m_left = W + 1;
                    end
                    3'd4: m_hi = a;
                    3'd5: m_lo = a;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end
        chk("cyc_busy", W'(busy), W'(m_busy));
        chk("cyc_done", W'(done), W'(m_done));
        chk("cyc_hi", hi, m_hi);
        chk("cyc_lo", lo, m_lo);
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busyc);
        lat   = 0;
        busyc = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busyc++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0: return '0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return W'($urandom % 16);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        int bc;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_busy", W'(busy), '0);

        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(lat, bc);
        chk("t1_latency", W'(lat + 1), 32'd34);
        chk("t1_busy_cycles", W'(bc), 32'd33);
        chk("t1_hi", hi, 32'h0000_0001);
        chk("t1_lo", lo, 32'hFFFF_FFFE);

        issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0005);
        wait_done(lat, bc);
        chk("t2_mult_hi", hi, 32'hFFFF_FFFF);
        chk("t2_mult_lo", lo, 32'hFFFF_FFF1);
        issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(lat, bc);
        chk("t2_div_lo", lo, 32'hFFFF_FFFD);
        chk("t2_div_hi", hi, 32'hFFFF_FFFF);
        issue(3'd2, 32'h0000_0007, 32'hFFFF_FFFE);
        wait_done(lat, bc);
        chk("t2_div2_lo", lo, 32'hFFFF_FFFD);
        chk("t2_div2_hi", hi, 32'h0000_0001);

        issue(3'd3, 32'h0000_0064, 32'h0000_0000);
        wait_done(lat, bc);
        chk("t3_div0_latency", W'(lat + 1), 32'd34);
        chk("t3_div0_lo", lo, 32'hFFFF_FFFF);
        chk("t3_div0_hi", hi, 32'h0000_0064);
        issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0000);
        wait_done(lat, bc);
        chk("t3_sdiv0_lo", lo, 32'hFFFF_FFFF);
        chk("t3_sdiv0_hi", hi, 32'hFFFF_FFF9);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        chk("t3_ovf_lo", lo, 32'h8000_0000);
        chk("t3_ovf_hi", hi, 32'h0000_0000);

        start = 1'b1; op = 3'd4; a = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("t4_mthi", hi, 32'h1234_5678);
        chk("t4_busy", W'(busy), '0);
        op = 3'd5; a = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t4_mtlo", lo, 32'h9ABC_DEF0);
        chk("t4_done", W'(done), '0);

        issue(3'd1, 32'd3, 32'd4);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        chk("t5_hi", hi, 32'h0000_0000);
        chk("t5_lo", lo, 32'h0000_000C);

        issue(3'd3, 32'd100, 32'd7);
        repeat (13) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("t6_busy", W'(busy), '0);
        chk("t6_done", W'(done), '0);
        chk("t6_hi", hi, '0);
        chk("t6_lo", lo, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        issue(3'd3, 32'd100, 32'd7);
        wait_done(lat, bc);
        chk("t6_lo2", lo, 32'h0000_000E);
        chk("t6_hi2", hi, 32'h0000_0002);

        repeat (3000) begin
            @(posedge clk);
            #1;
            start = ($urandom % 3) == 0;
            op    = 3'($urandom % 8);
            a     = pick();
            b     = pick();
        end
        start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
